// File: rtl/matmul_iter_control.sv
// matmul_iter_control
//   Iteration controller and dot-product engine for the DIM x DIM matrix
//   multiplier (C = A x B). Once the loader reports `complete`, every
//   (A row, B column) pair is requested in raster order (column fastest).
//   Each pair is reduced to one C element by a MAC loop that handles
//   MACS_PER_CYCLE products per cycle. The element is then emitted with
//   its coordinates.
//
//   Ports
//     clk_in, rst_in           clock, asynchronous active-low reset
//     complete                 loader finished (sampled only in IDLE)
//     matA_row, matB_col       returned vectors, element k at [k*ELEM_W +: ELEM_W]
//     row_in, col_in, val_rows address tags and qualifier of the returned vectors
//     new_request, row_req, col_req        vector request to the loader
//     matrix_val, row_out, col_out, valid_out  C element to the compiler
//     done                     high once all DIM*DIM elements are emitted
//
//   Build option
//     ITER_CONTROL_SAT_EN : full-width products and accumulator, and the
//                           result saturates at 2^ELEM_W-1. When undefined,
//                           accumulation is modulo 2^ELEM_W.
module matmul_iter_control #(
  parameter  int DIM            = 32,
  parameter  int ELEM_W         = 8,
  parameter  int MACS_PER_CYCLE = 4,
  localparam int AW             = $clog2(DIM),
  localparam int VEC_W          = DIM * ELEM_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              complete,
  input  logic [VEC_W-1:0]  matA_row,
  input  logic [VEC_W-1:0]  matB_col,
  input  logic [AW-1:0]     row_in,
  input  logic [AW-1:0]     col_in,
  input  logic              val_rows,
  output logic              new_request,
  output logic [AW-1:0]     row_req,
  output logic [AW-1:0]     col_req,
  output logic [ELEM_W-1:0] matrix_val,
  output logic [AW-1:0]     row_out,
  output logic [AW-1:0]     col_out,
  output logic              valid_out,
  output logic              done
);

`ifdef ITER_CONTROL_SAT_EN
  localparam int ACC_W = 2 * ELEM_W + AW;
`else
  localparam int ACC_W = ELEM_W;
`endif

  localparam int          MAC_CYCLES = DIM / MACS_PER_CYCLE;
  localparam int          CNT_W      = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
  localparam int unsigned MPC_U      = MACS_PER_CYCLE;
  localparam int unsigned EW_U       = ELEM_W;
  localparam int          PROD_W     = 2 * ELEM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MAC,
    S_OUT,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       i_q, i_d;
  logic [AW-1:0]       j_q, j_d;
  logic [VEC_W-1:0]    a_q, a_d;
  logic [VEC_W-1:0]    b_q, b_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    mac_cnt_q, mac_cnt_d;
  logic                new_request_q, new_request_d;
  logic [AW-1:0]       row_req_q, row_req_d;
  logic [AW-1:0]       col_req_q, col_req_d;
  logic [ELEM_W-1:0]   matrix_val_q, matrix_val_d;
  logic [AW-1:0]       row_out_q, row_out_d;
  logic [AW-1:0]       col_out_q, col_out_d;
  logic                valid_out_q, valid_out_d;
  logic                done_q, done_d;

  logic [ACC_W-1:0]    mac_sum;
  logic [ELEM_W-1:0]   out_val;
  logic [PROD_W-1:0]   prod;
  int unsigned         base;

  // One MAC step: MACS_PER_CYCLE products of slice mac_cnt_q, lowest k first.
  // In the modulo build the product is truncated by the cast to ACC_W.
  always_comb begin
    mac_sum = acc_q;
    prod    = '0;
    base    = 0;
    for (int unsigned m = 0; m < MPC_U; m++) begin
      base    = (32'(mac_cnt_q) * MPC_U + m) * EW_U;
      prod    = PROD_W'(a_q[base +: ELEM_W]) * PROD_W'(b_q[base +: ELEM_W]);
      mac_sum = mac_sum + ACC_W'(prod);
    end
  end

`ifdef ITER_CONTROL_SAT_EN
  always_comb begin
    out_val = acc_q[ELEM_W-1:0];
    if (acc_q > ACC_W'((1 << ELEM_W) - 1)) out_val = '1;
  end
`else
  always_comb out_val = acc_q;
`endif

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    a_d           = a_q;
    b_d           = b_q;
    acc_d         = acc_q;
    mac_cnt_d     = mac_cnt_q;
    new_request_d = 1'b0;
    row_req_d     = row_req_q;
    col_req_d     = col_req_q;
    matrix_val_d  = matrix_val_q;
    row_out_d     = row_out_q;
    col_out_d     = col_out_q;
    valid_out_d   = 1'b0;
    done_d        = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (complete) begin
          state_d = S_REQ;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_REQ: begin
        new_request_d = 1'b1;
        row_req_d     = i_q;
        col_req_d     = j_q;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (val_rows && (row_in == i_q) && (col_in == j_q)) begin
          a_d       = matA_row;
          b_d       = matB_col;
          acc_d     = '0;
          mac_cnt_d = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        acc_d     = mac_sum;
        mac_cnt_d = mac_cnt_q + 1'b1;
        if (mac_cnt_q == CNT_W'(MAC_CYCLES - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        matrix_val_d = out_val;
        row_out_d    = i_q;
        col_out_d    = j_q;
        valid_out_d  = 1'b1;
        if (j_q == AW'(DIM - 1)) begin
          j_d = '0;
          i_d = (i_q == AW'(DIM - 1)) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if ((i_q == AW'(DIM - 1)) && (j_q == AW'(DIM - 1))) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      mac_cnt_q     <= '0;
      new_request_q <= 1'b0;
      row_req_q     <= '0;
      col_req_q     <= '0;
      matrix_val_q  <= '0;
      row_out_q     <= '0;
      col_out_q     <= '0;
      valid_out_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      mac_cnt_q     <= mac_cnt_d;
      new_request_q <= new_request_d;
      row_req_q     <= row_req_d;
      col_req_q     <= col_req_d;
      matrix_val_q  <= matrix_val_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      valid_out_q   <= valid_out_d;
      done_q        <= done_d;
    end
  end

  assign new_request = new_request_q;
  assign row_req     = row_req_q;
  assign col_req     = col_req_q;
  assign matrix_val  = matrix_val_q;
  assign row_out     = row_out_q;
  assign col_out     = col_out_q;
  assign valid_out   = valid_out_q;
  assign done        = done_q;

endmodule

// File: tb/tb_matmul_iter_control.sv
// Bench for matmul_iter_control: a loader model answers requests from
// matrices held in the bench. A reference computes every C element
// directly as a dot product, and a monitor checks requests, outputs and
// done on every cycle.
module tb_matmul_iter_control;
  localparam int DIM = 32;
  localparam int VW  = 256;
  localparam int NEL = DIM * DIM;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          complete = 1'b0;
  logic [VW-1:0] matA_row = '0;
  logic [VW-1:0] matB_col = '0;
  logic [4:0]    row_in = '0;
  logic [4:0]    col_in = '0;
  logic          val_rows = 1'b0;
  logic          new_request;
  logic [4:0]    row_req, col_req;
  logic [7:0]    matrix_val;
  logic [4:0]    row_out, col_out;
  logic          valid_out, done;

  always #5 clk_in = ~clk_in;

  matmul_iter_control #(.DIM(32), .ELEM_W(8), .MACS_PER_CYCLE(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .complete(complete),
    .matA_row(matA_row), .matB_col(matB_col), .row_in(row_in), .col_in(col_in),
    .val_rows(val_rows), .new_request(new_request), .row_req(row_req),
    .col_req(col_req), .matrix_val(matrix_val), .row_out(row_out),
    .col_out(col_out), .valid_out(valid_out), .done(done)
  );

  bit [7:0] mat_a [DIM][DIM];
  bit [7:0] mat_b [DIM][DIM];
  int vectors = 0, miscompares = 0;
  int exp_idx = 0, req_idx = 0;
  int pin_mode = 0;
  bit lat_rand = 0, noise = 0, filt_en = 0;
  logic [4:0] ld_r = '0, ld_c = '0;

`ifdef ITER_CONTROL_SAT_EN
  localparam int PIN_C12  = 255;
  localparam int PIN_WRAP = 255;
`else
  localparam int PIN_C12  = 3;
  localparam int PIN_WRAP = 0;
`endif

  function automatic int model_c(int i, int j);
    int s = 0;
    for (int k = 0; k < DIM; k++) s += int'(mat_a[i][k]) * int'(mat_b[k][j]);
`ifdef ITER_CONTROL_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  function automatic logic [VW-1:0] row_vec(int r);
    logic [VW-1:0] v;
    for (int k = 0; k < DIM; k++) v[8*k +: 8] = mat_a[r][k];
    return v;
  endfunction

  function automatic logic [VW-1:0] col_vec(int c);
    logic [VW-1:0] v;
    for (int k = 0; k < DIM; k++) v[8*k +: 8] = mat_b[k][c];
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] c,
                       input logic [VW-1:0] a, input logic [VW-1:0] b);
    val_rows = 1'b1; row_in = r; col_in = c; matA_row = a; matB_col = b;
  endtask

  // Loader model: answers each request after a latency, optionally
  // surrounded by wrong-address traffic and by traffic outside WAIT.
  initial begin : loader
    int lat;
    logic [4:0] br, bc;
    forever begin
      @(negedge clk_in);
      val_rows = 1'b0;
      if (rst_in && new_request) begin
        ld_r = row_req; ld_c = col_req;
        if (filt_en && ld_r == 5'd4 && ld_c == 5'd7) begin
          drive(5'd4, 5'd6, rand_vec(), rand_vec());
          @(negedge clk_in);
          drive(5'd5, 5'd7, rand_vec(), rand_vec());
          @(negedge clk_in);
          drive(ld_r, ld_c, row_vec(ld_r), col_vec(ld_c));
        end else begin
          lat = lat_rand ? int'($urandom_range(0, 4)) : 2;
          for (int n = 0; n < lat; n++) begin
            if (noise && $urandom_range(0, 1) == 1) begin
              br = ld_r; bc = ld_c;
              case ($urandom_range(0, 2))
                0: br = ld_r + 5'($urandom_range(1, 31));
                1: bc = ld_c + 5'($urandom_range(1, 31));
                default: begin
                  br = ld_r + 5'($urandom_range(1, 31));
                  bc = ld_c + 5'($urandom_range(1, 31));
                end
              endcase
              drive(br, bc, rand_vec(), rand_vec());
            end else begin
              val_rows = 1'b0;
            end
            @(negedge clk_in);
          end
          drive(ld_r, ld_c, row_vec(ld_r), col_vec(ld_c));
        end
      end else if (rst_in && noise && $urandom_range(0, 2) == 0) begin
        // correctly addressed but arriving outside WAIT
        drive(ld_r, ld_c, rand_vec(), rand_vec());
      end
    end
  end

  // Monitor: requests, emitted elements and done against the reference.
  always @(negedge clk_in) begin
    int ei, ej;
    if (!rst_in) begin
      exp_idx = 0;
      req_idx = 0;
      check("reset_outputs_zero",
            int'(|{new_request, row_req, col_req, matrix_val, row_out, col_out, valid_out, done}), 0);
    end else begin
      if (new_request) begin
        check("request_in_range", int'(req_idx < NEL), 1);
        check("row_req", int'(row_req), req_idx / DIM);
        check("col_req", int'(col_req), req_idx % DIM);
        req_idx++;
      end
      if (valid_out) begin
        ei = exp_idx / DIM;
        ej = exp_idx % DIM;
        check("output_in_range", int'(exp_idx < NEL), 1);
        check("row_out", int'(row_out), ei);
        check("col_out", int'(col_out), ej);
        check("matrix_val", int'(matrix_val), model_c(ei, ej));
        if (pin_mode == 1 && ei == 1 && ej == 2) check("pin_c_1_2", int'(matrix_val), PIN_C12);
        if (pin_mode == 1 && ei == 10 && ej == 0) check("pin_c_10_0", int'(matrix_val), 0);
        if (pin_mode == 2) check("pin_wrap", int'(matrix_val), PIN_WRAP);
        exp_idx++;
      end
      check("done", int'(done), int'(exp_idx >= NEL));
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk_in); n++; end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL wait_done: done still 0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic wait_req(input int r, input int c, input int budget);
    int n = 0;
    do begin @(negedge clk_in); n++; end
    while (!(new_request && int'(row_req) == r && int'(col_req) == c) && n < budget);
    if (!(new_request && int'(row_req) == r && int'(col_req) == c)) begin
      vectors++; miscompares++;
      $display("FAIL wait_req: no request for (%0d,%0d) within %0d cycles", r, c, budget);
    end
  endtask

  task automatic assert_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin mat_a[i][k] = 8'h00; mat_b[i][k] = 8'h00; end

    // Reset, then idle with complete low
    repeat (5) @(negedge clk_in);
    release_reset();
    repeat (100) begin
      @(negedge clk_in);
      check("idle_outputs_zero",
            int'(|{new_request, row_req, col_req, matrix_val, row_out, col_out, valid_out, done}), 0);
    end

    // Full run: 0xFF block pattern, address filtering at (4,7), complete dropped early
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin mat_a[i][k] = 8'hFF; mat_b[k][i] = 8'hFF; end
    pin_mode = 1; filt_en = 1;
    complete = 1'b1;
    wait_req(0, 0, 50);
    complete = 1'b0;
    wait_done(20000);
    repeat (30) @(negedge clk_in);
    check("run1_element_count", exp_idx, NEL);
    check("run1_request_count", req_idx, NEL);
    check("done_held", int'(done), 1);

    // Wrap / saturation, with reset during MAC of (2,5)
    assert_reset();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin mat_a[i][k] = 8'h10; mat_b[i][k] = 8'h10; end
    pin_mode = 2; filt_en = 0;
    complete = 1'b1;
    release_reset();
    wait_req(2, 5, 2000);
    repeat (5) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1 check("mid_reset_outputs_zero",
             int'(|{new_request, row_req, col_req, matrix_val, row_out, col_out, valid_out, done}), 0);
    repeat (3) @(negedge clk_in);
    release_reset();
    n = 0;
    while (exp_idx < 8 && n < 1000) begin @(negedge clk_in); n++; end
    check("restart_elements_seen", int'(exp_idx >= 8), 1);

    // Random matrices, random latency, wrong-address and out-of-WAIT traffic
    assert_reset();
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++) begin
        mat_a[i][k] = 8'($urandom_range(0, 255));
        mat_b[i][k] = 8'($urandom_range(0, 255));
      end
    pin_mode = 0; noise = 1; lat_rand = 1;
    release_reset();
    wait_done(25000);
    repeat (20) @(negedge clk_in);
    check("run3_element_count", exp_idx, NEL);
    noise = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
